// File: rtl/eth_frame_tx.sv
// RMII Ethernet frame transmitter: preamble/SFD, fixed header, streamed payload,
// zero padding to the minimum frame size and CRC-32 FCS, followed by an inter-packet gap.
module eth_frame_tx #(
  parameter logic [47:0] DST_MAC     = 48'hFF_FF_FF_FF_FF_FF,
  parameter logic [47:0] SRC_MAC     = 48'h69_69_5A_06_54_91,
  parameter logic [15:0] ETHERTYPE   = 16'h88B5,
  parameter int unsigned MAX_PAYLOAD = 1500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send,
  input  logic       axiiv,
  input  logic [1:0] axiid,
  output logic       stall,
  output logic       txen,
  output logic [1:0] txd,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, PREAMBLE, HEADER, PAYLOAD, PAD, FCS, IPG
  } state_e;

  localparam logic [111:0] HDR         = {DST_MAC, SRC_MAC, ETHERTYPE};
  localparam logic [13:0]  MAX_DIBITS  = 14'(MAX_PAYLOAD * 4);
  localparam logic [13:0]  MIN_DIBITS  = 14'd184;

  state_e      state_q;
  logic [5:0]  ph_q;
  logic [13:0] cnt_q;
  logic [31:0] crc_q;
  logic        txen_q;
  logic [1:0]  txd_q;
  logic        stall_q;

  logic [6:0]  hdr_sh_d;
  logic [1:0]  hdr_dibit_d;
  logic [1:0]  fcs_dibit_d;
  logic [13:0] cnt_inc_d;

  function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
    logic [31:0] r;
    r = c;
    for (int unsigned i = 0; i < 2; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  function automatic logic pad_done(input logic [13:0] c);
    return (c[1:0] == 2'b00) && (c >= MIN_DIBITS);
  endfunction

  // Header is sent most-significant byte first, each byte LSb dibit first.
  always_comb begin
    hdr_sh_d    = 7'd104 - {ph_q[5:2], 3'b000} + {4'b0000, ph_q[1:0], 1'b0};
    hdr_dibit_d = 2'(HDR >> hdr_sh_d);
    fcs_dibit_d = 2'(~crc_q >> {ph_q[3:0], 1'b0});
    cnt_inc_d   = cnt_q + 14'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ph_q    <= '0;
      cnt_q   <= '0;
      crc_q   <= '1;
      txen_q  <= 1'b0;
      txd_q   <= '0;
      stall_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          txen_q  <= 1'b0;
          txd_q   <= '0;
          stall_q <= 1'b1;
          ph_q    <= '0;
          cnt_q   <= '0;
          crc_q   <= '1;
          if (send) state_q <= PREAMBLE;
        end
        PREAMBLE: begin
          txen_q <= 1'b1;
          txd_q  <= (ph_q == 6'd31) ? 2'b11 : 2'b01;
          if (ph_q == 6'd31) begin
            ph_q    <= '0;
            state_q <= HEADER;
          end else begin
            ph_q <= ph_q + 6'd1;
          end
        end
        HEADER: begin
          txen_q <= 1'b1;
          txd_q  <= hdr_dibit_d;
          crc_q  <= crc_dibit(crc_q, hdr_dibit_d);
          if (ph_q == 6'd54) stall_q <= 1'b0;
          if (ph_q == 6'd55) begin
            ph_q    <= '0;
            state_q <= PAYLOAD;
          end else begin
            ph_q <= ph_q + 6'd1;
          end
        end
        PAYLOAD: begin
          txen_q <= 1'b1;
          if (axiiv) begin
            txd_q <= axiid;
            crc_q <= crc_dibit(crc_q, axiid);
            cnt_q <= cnt_inc_d;
            if (cnt_inc_d == MAX_DIBITS) begin
              stall_q <= 1'b1;
              ph_q    <= '0;
              state_q <= FCS;
            end
          end else begin
            stall_q <= 1'b1;
            if (pad_done(cnt_q)) begin
              // No padding needed: this cycle carries FCS dibit 0 so txen has no gap.
              txd_q   <= fcs_dibit_d;
              ph_q    <= 6'd1;
              state_q <= FCS;
            end else begin
              txd_q   <= '0;
              crc_q   <= crc_dibit(crc_q, 2'b00);
              cnt_q   <= cnt_inc_d;
              ph_q    <= '0;
              state_q <= pad_done(cnt_inc_d) ? FCS : PAD;
            end
          end
        end
        PAD: begin
          txen_q <= 1'b1;
          txd_q  <= '0;
          crc_q  <= crc_dibit(crc_q, 2'b00);
          cnt_q  <= cnt_inc_d;
          ph_q   <= '0;
          if (pad_done(cnt_inc_d)) state_q <= FCS;
        end
        FCS: begin
          txen_q <= 1'b1;
          txd_q  <= fcs_dibit_d;
          if (ph_q == 6'd15) begin
            ph_q    <= '0;
            state_q <= IPG;
          end else begin
            ph_q <= ph_q + 6'd1;
          end
        end
        IPG: begin
          txen_q <= 1'b0;
          txd_q  <= '0;
          if (ph_q == 6'd47) begin
            ph_q    <= '0;
            state_q <= IDLE;
          end else begin
            ph_q <= ph_q + 6'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign txen  = txen_q;
  assign txd   = txd_q;
  assign stall = stall_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_eth_frame_tx.sv
// Directed bench for eth_frame_tx: frame-level vectors compared against a software
// frame builder with byte-wise CRC-32, plus reset and back-to-back sequences.
module tb_eth_frame_tx;

  localparam logic [47:0] DST = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [47:0] SRC = 48'h69_69_5A_06_54_91;
  localparam logic [15:0] ET  = 16'h88B5;

  logic       clk = 1'b0;
  logic       rst, send, axiiv;
  logic [1:0] axiid;
  logic       stall, txen, busy;
  logic [1:0] txd;

  eth_frame_tx #(
    .DST_MAC(DST), .SRC_MAC(SRC), .ETHERTYPE(ET), .MAX_PAYLOAD(1500)
  ) dut (
    .clk(clk), .rst(rst), .send(send), .axiiv(axiiv), .axiid(axiid),
    .stall(stall), .txen(txen), .txd(txd), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string name;
    int    n_supply;
    int    pat;
    bit    noise;
    int    exp_pl;
    int    exp_pad;
    int    exp_txen;
    int    exp_stall_low;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pay_byte(input int pat, input int i);
    if (pat == 0) return 8'hA5;
    return 8'(i * 37 + 11);
  endfunction

  function automatic logic [1:0] pay_dibit(input int pat, input int k);
    logic [7:0] b;
    b = pay_byte(pat, k / 4);
    return 2'(b >> (2 * (k % 4)));
  endfunction

  function automatic logic [31:0] crc32_fcs(input logic [7:0] q[$]);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (q[i]) begin
      c = c ^ {24'd0, q[i]};
      for (int b = 0; b < 8; b++)
        c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic run_frame(input vec_t v);
    logic [1:0]   exp_q[$];
    logic [1:0]   got[$];
    logic [7:0]   bytes_q[$];
    logic [111:0] hdr;
    logic [7:0]   hb;
    logic [31:0]  fcs, got_fcs;
    int           k, stall_low, mism;
    bit           seen, done, sp;

    // expected dibit stream
    for (int i = 0; i < 31; i++) exp_q.push_back(2'b01);
    exp_q.push_back(2'b11);
    hdr = {DST, SRC, ET};
    for (int b = 0; b < 14; b++) begin
      hb = hdr[111 - 8 * b -: 8];
      for (int j = 0; j < 4; j++) exp_q.push_back(2'(hb >> (2 * j)));
    end
    for (int i = 0; i < v.exp_pl; i++) exp_q.push_back(pay_dibit(v.pat, i));
    for (int i = 0; i < v.exp_pad; i++) exp_q.push_back(2'b00);
    for (int i = 32; i + 3 < exp_q.size(); i += 4)
      bytes_q.push_back({exp_q[i + 3], exp_q[i + 2], exp_q[i + 1], exp_q[i]});
    fcs = crc32_fcs(bytes_q);
    for (int i = 0; i < 16; i++) exp_q.push_back(2'(fcs >> (2 * i)));

    k = 0; stall_low = 0; seen = 0; done = 0;
    @(posedge clk); #1;
    send = 1'b1;
    for (int cyc = 0; cyc < 8000 && !done; cyc++) begin
      @(negedge clk);
      sp = stall;
      if (!stall) stall_low++;
      if (txen) begin
        got.push_back(txd);
        seen = 1;
      end else if (seen) begin
        done = 1;
      end
      @(posedge clk); #1;
      send = 1'b0;
      if (!sp && k < v.n_supply) begin
        axiiv = 1'b1;
        axiid = pay_dibit(v.pat, k);
        k++;
      end else if (sp && v.noise) begin
        axiiv = 1'b1;
        axiid = 2'($urandom_range(0, 3));
      end else begin
        axiiv = 1'b0;
        axiid = '0;
      end
    end
    axiiv = 1'b0;

    check({v.name, " frame_ended"}, 64'(done), 64'd1);
    check({v.name, " txen_len"}, 64'(got.size()), 64'(v.exp_txen));
    mism = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= got.size() || got[i] !== exp_q[i]) mism++;
    check({v.name, " stream_errors"}, 64'(mism), 64'd0);
    check({v.name, " sfd"}, 64'((got.size() > 31) ? got[31] : 2'bxx), 64'(2'b11));
    got_fcs = 'x;
    if (got.size() >= 16)
      for (int i = 0; i < 16; i++) got_fcs[2 * i +: 2] = got[got.size() - 16 + i];
    check({v.name, " fcs"}, 64'(got_fcs), 64'(fcs));
    check({v.name, " stall_low_cycles"}, 64'(stall_low), 64'(v.exp_stall_low));
    for (int c = 0; c < 100 && busy; c++) @(negedge clk);
    check({v.name, " back_to_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int phase, hi1, lo, hi2;
    vecs[0] = '{"basic",    1280, 0, 1'b0, 1280,   0, 1384, 1282};
    vecs[1] = '{"short8B",    32, 1, 1'b1,   32, 152,  288,   34};
    vecs[2] = '{"empty",       0, 1, 1'b1,    0, 184,  288,    2};
    vecs[3] = '{"overlong", 6010, 1, 1'b0, 6000,   0, 6104, 6001};
    vecs[4] = '{"five",        5, 1, 1'b1,    5, 179,  288,    7};
    vecs[5] = '{"p183",      183, 1, 1'b0,  183,   1,  288,  185};
    vecs[6] = '{"p184",      184, 1, 1'b1,  184,   0,  288,  186};
    vecs[7] = '{"p190",      190, 1, 1'b0,  190,   2,  296,  192};

    rst = 1'b1; send = 1'b0; axiiv = 1'b0; axiid = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset txen", 64'(txen), 64'd0);
    check("reset txd", 64'(txd), 64'd0);
    check("reset stall", 64'(stall), 64'd1);
    check("reset busy", 64'(busy), 64'd0);

    foreach (vecs[i]) run_frame(vecs[i]);

    // reset in the middle of a payload
    @(posedge clk); #1 send = 1'b1;
    @(posedge clk); #1 send = 1'b0; axiiv = 1'b1; axiid = 2'b10;
    repeat (150) @(posedge clk);
    @(negedge clk);
    check("midrst pre stall", 64'(stall), 64'd0);
    check("midrst pre txen", 64'(txen), 64'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; axiiv = 1'b0; axiid = '0;
    @(negedge clk);
    check("midrst txen", 64'(txen), 64'd0);
    check("midrst txd", 64'(txd), 64'd0);
    check("midrst stall", 64'(stall), 64'd1);
    check("midrst busy", 64'(busy), 64'd0);
    begin
      vec_t v;
      v = vecs[0];
      v.name = "basic_after_reset";
      run_frame(v);
    end

    // send held high: IPG ignores send, frames separated by 49 txen-low cycles
    phase = 0; hi1 = 0; lo = 0; hi2 = 0;
    @(posedge clk); #1 send = 1'b1; axiiv = 1'b0;
    for (int cyc = 0; cyc < 1500 && phase < 4; cyc++) begin
      @(negedge clk);
      case (phase)
        0: if (txen) begin phase = 1; hi1 = 1; end
        1: if (txen) hi1++; else begin phase = 2; lo = 1; end
        2: if (!txen) lo++; else begin phase = 3; hi2 = 1; end
        3: if (txen) hi2++; else phase = 4;
        default: ;
      endcase
      @(posedge clk); #1;
      if (phase >= 3) send = 1'b0;
    end
    check("held first_len", 64'(hi1), 64'd288);
    check("held gap", 64'(lo), 64'd49);
    check("held second_len", 64'(hi2), 64'd288);
    for (int c = 0; c < 100 && busy; c++) @(negedge clk);
    repeat (60) @(negedge clk);
    check("held no_third_frame", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
